// File: rtl/if_redirect_stage.sv
// ============================================================================
// Module   : if_redirect_stage
// Brief    : PC generation / instruction fetch with buffered branch redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_redirect_stage #(
    parameter logic [31:0] RESET_PC        = 32'h1C00_0000,
    parameter int          BR_BUS_WD       = 33,
    parameter int          FS_TO_DS_BUS_WD = 65
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic [31:0]                flush_target,
    input  logic [5:0]                 stall,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       br_taken_buffer,
    output logic                       inst_sram_en,
    output logic [31:0]                inst_sram_addr,
    input  logic [31:0]                inst_sram_rdata,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

    localparam logic [31:0] C_PC_STEP = 32'd4;

    logic [31:0] r_pc;
    logic        r_fs_valid;
    logic        r_buf_valid;
    logic [31:0] r_buf_target;
    logic        r_ibuf_valid;
    logic [31:0] r_ibuf_data;

    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic [31:0] w_next_pc;
    logic        w_cancel;
    logic        w_adef;
    logic [31:0] w_inst;

    assign w_br_taken  = br_bus[32];
    assign w_br_target = br_bus[31:0];

    always_comb begin
        w_next_pc = r_pc + C_PC_STEP;
        if (flush) begin
            w_next_pc = flush_target;
        end else if (w_br_taken) begin
            w_next_pc = w_br_target;
        end else if (r_buf_valid) begin
            w_next_pc = r_buf_target;
        end else if (stall[0]) begin
            w_next_pc = r_pc;
        end
    end

    // The slot currently in IF is wrong-path whenever any redirect is live.
    assign w_cancel = flush | w_br_taken | r_buf_valid;
    assign w_adef   = (r_pc[1:0] != 2'b00);
    assign w_inst   = r_ibuf_valid ? r_ibuf_data : inst_sram_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc         <= RESET_PC - C_PC_STEP;
            r_fs_valid   <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_buf_target <= 32'd0;
            r_ibuf_valid <= 1'b0;
            r_ibuf_data  <= 32'd0;
        end else begin
            // stall[1] implies stall[0], so !stall[0] alone means fully unstalled.
            if (flush || !stall[0]) begin
                r_pc <= w_next_pc;
            end

            if (flush || !stall[1]) begin
                r_fs_valid <= ~stall[0];
            end

            if (flush) begin
                r_buf_valid <= 1'b0;
            end else if (w_br_taken && stall[0]) begin
                r_buf_valid  <= 1'b1;
                r_buf_target <= w_br_target;
            end else if (!stall[0]) begin
                r_buf_valid <= 1'b0;
            end

            if (flush || !stall[1]) begin
                r_ibuf_valid <= 1'b0;
            end else if (r_fs_valid && !r_ibuf_valid) begin
                r_ibuf_valid <= 1'b1;
                r_ibuf_data  <= inst_sram_rdata;
            end
        end
    end

    assign br_taken_buffer = resetn & r_buf_valid;
    assign inst_sram_en    = resetn & ~stall[0] & (w_next_pc[1:0] == 2'b00);
    assign inst_sram_addr  = w_next_pc;

    always_comb begin
        fs_to_ds_bus = '0;
        if (resetn && r_fs_valid && !w_cancel) begin
            fs_to_ds_bus = w_adef ? {1'b1, r_pc, 32'd0} : {1'b0, r_pc, w_inst};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_redirect_stage.sv
// ============================================================================
// Module   : tb_if_redirect_stage
// Brief    : Directed self-checking bench for if_redirect_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_redirect_stage;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [31:0] flush_target;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic        br_taken_buffer;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic [64:0] fs_to_ds_bus;
    logic        garble;

    int compared = 0;
    int mismatched = 0;

    if_redirect_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .flush_target    (flush_target),
        .stall           (stall),
        .br_bus          (br_bus),
        .br_taken_buffer (br_taken_buffer),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .fs_to_ds_bus    (fs_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: word at addr is ~addr; while garble is set an idle SRAM churns its output.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= ~inst_sram_addr;
        else if (garble)
            inst_sram_rdata <= inst_sram_rdata + 32'h1111_1111;
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [64:0] slot(input logic [31:0] pc);
        return {1'b0, pc, ~pc};
    endfunction

    initial begin
        resetn = 1'b0; flush = 1'b0; flush_target = 32'd0;
        stall = 6'd0; br_bus = 33'd0; garble = 1'b0;
        inst_sram_rdata = 32'd0;
        tick(); tick();
        chk("rst_en",  {64'd0, inst_sram_en}, 65'd0);
        chk("rst_bus", fs_to_ds_bus, 65'd0);
        chk("rst_btb", {64'd0, br_taken_buffer}, 65'd0);

        // Reset release and sequential fetch
        resetn = 1'b1; #1;
        chk("c1_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_0000});
        chk("c1_en",   {64'd0, inst_sram_en}, 65'd1);
        tick();
        chk("c2_bus",  fs_to_ds_bus, slot(32'h1C00_0000));
        chk("c2_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_0004});
        tick();
        chk("c3_bus",  fs_to_ds_bus, slot(32'h1C00_0004));
        tick();
        chk("c4_bus",  fs_to_ds_bus, slot(32'h1C00_0008));

        // Unstalled branch at pc=0x1C000008
        br_bus = {1'b1, 32'h1C00_0100}; #1;
        chk("br_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_0100});
        chk("br_en",   {64'd0, inst_sram_en}, 65'd1);
        chk("br_bus0", fs_to_ds_bus, 65'd0);
        chk("br_btb",  {64'd0, br_taken_buffer}, 65'd0);
        tick();
        br_bus = 33'd0; #1;
        chk("br_tgt",  fs_to_ds_bus, slot(32'h1C00_0100));
        chk("br_btb2", {64'd0, br_taken_buffer}, 65'd0);

        // Branch under PC stall gets buffered
        stall = 6'b000001; br_bus = {1'b1, 32'h1C00_0200}; #1;
        chk("bb_en0",  {64'd0, inst_sram_en}, 65'd0);
        chk("bb_bus0", fs_to_ds_bus, 65'd0);
        tick();
        br_bus = 33'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bb_btb", {64'd0, br_taken_buffer}, 65'd1);
            chk("bb_en",  {64'd0, inst_sram_en}, 65'd0);
            chk("bb_bus", fs_to_ds_bus, 65'd0);
            tick();
        end
        stall = 6'd0; #1;
        chk("bb_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_0200});
        chk("bb_en1",  {64'd0, inst_sram_en}, 65'd1);
        chk("bb_btb1", {64'd0, br_taken_buffer}, 65'd1);
        chk("bb_bus1", fs_to_ds_bus, 65'd0);
        tick();
        chk("bb_clr",  {64'd0, br_taken_buffer}, 65'd0);
        chk("bb_tgt",  fs_to_ds_bus, slot(32'h1C00_0200));

        // Flush during a buffered stall
        stall = 6'b000001; br_bus = {1'b1, 32'h1C00_0200};
        tick();
        br_bus = 33'd0; #1;
        chk("fl_btb1", {64'd0, br_taken_buffer}, 65'd1);
        flush = 1'b1; flush_target = 32'h1C00_C000; #1;
        chk("fl_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_C000});
        chk("fl_bus",  fs_to_ds_bus, 65'd0);
        tick();
        flush = 1'b0; #1;
        chk("fl_btb0", {64'd0, br_taken_buffer}, 65'd0);

        // Reset with a pending buffer while stalled
        br_bus = {1'b1, 32'h1C00_0400};
        tick();
        br_bus = 33'd0; #1;
        chk("rs_btb1", {64'd0, br_taken_buffer}, 65'd1);
        resetn = 1'b0;
        tick();
        chk("rs_btb0", {64'd0, br_taken_buffer}, 65'd0);
        chk("rs_en",   {64'd0, inst_sram_en}, 65'd0);
        chk("rs_bus",  fs_to_ds_bus, 65'd0);
        tick();
        resetn = 1'b1; stall = 6'd0; #1;
        chk("rs_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_0000});
        chk("rs_btb",  {64'd0, br_taken_buffer}, 65'd0);
        tick();
        chk("rs_bus1", fs_to_ds_bus, slot(32'h1C00_0000));
        tick();

        // IF stall holds the first captured instruction
        stall = 6'b000011; garble = 1'b1; #1;
        chk("ib_bus0", fs_to_ds_bus, slot(32'h1C00_0004));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ib_hold", fs_to_ds_bus, slot(32'h1C00_0004));
        end
        stall = 6'd0; garble = 1'b0; #1;
        chk("ib_rel",  fs_to_ds_bus, slot(32'h1C00_0004));
        chk("ib_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_0008});
        tick();
        chk("ib_next", fs_to_ds_bus, slot(32'h1C00_0008));

        // Misaligned branch target raises adef without an SRAM read
        br_bus = {1'b1, 32'h1C00_0102}; #1;
        chk("ad_en",   {64'd0, inst_sram_en}, 65'd0);
        chk("ad_addr", {33'd0, inst_sram_addr}, {33'd0, 32'h1C00_0102});
        tick();
        br_bus = 33'd0; #1;
        chk("ad_bus",  fs_to_ds_bus, {1'b1, 32'h1C00_0102, 32'd0});
        chk("ad_en2",  {64'd0, inst_sram_en}, 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
